target_sequencer: RTL and testbench
===================================

# target_sequencer

Prompt generator for the button reaction game: lights one of three target LEDs in pseudo-random order, times a response window, and classifies the debounced button hits as score or miss. It drives the player-facing LEDs and feeds its score pulse into the 6-bit score counter, which then drives the 7-segment decoder. It sits between the three debouncers and the score counter, replacing the ad-hoc AND gating of button and target.

## Interface
- WINDOW_TICKS, 50_000_000: length of the response window in clk cycles (1 s at 50 MHz); ≥ 2
- GAP_TICKS, 12_500_000: dark gap between prompts in clk cycles; ≥ 1
- ROUNDS, 60: prompts per game; 1..63
- MIN_WINDOW_TICKS, 12_500_000: window floor, used only with the speedup feature
- LFSR_SEED, 16'hACE1: LFSR reset value; nonzero
- clk  in  1  system clock
- reset  in  1  asynchronous, active-low reset
- start  in  1  single-cycle pulse starting a game; ignored while busy
- btn_hit  in  3  single-cycle debounced press pulses; bit i = button i+1
- target  out  3  one-hot prompt LEDs, active-high; 0 when dark
- score_pulse  out  1  one-cycle pulse per correct hit; drives the score counter clock-enable
- miss_pulse  out  1  one-cycle pulse per wrong press or timeout
- busy  out  1  game in progress
- round_cnt  out  6  prompts completed in current or last game

## Operation
- 16-bit Galois LFSR with taps 0xB400, free-running every clk; it also runs in IDLE, so start time randomizes the sequence.
- Target pick: idx = lfsr[1:0]. Value 3 maps to (previous idx + 1) mod 3. Previous idx resets to 0.
- FSM states: IDLE, SHOW, GAP, DONE.
  - IDLE/DONE: target=0, busy=0. On start: round_cnt:=0, pick target, timer:=window-1, go to SHOW. DONE holds round_cnt.
  - SHOW: target one-hot, busy=1.
    - btn_hit equal to target (exactly one bit): score_pulse, go to GAP.
    - Any other nonzero btn_hit (wrong bit or multiple bits): miss_pulse, go to GAP.
    - timer==0 with btn_hit==0: miss_pulse, go to GAP.
    - A valid hit in the timer==0 cycle counts as a score.
    - On exit: round_cnt += 1, timer:=GAP_TICKS-1.
  - GAP: target=0, busy=1, btn_hit ignored. At timer==0: DONE if round_cnt==ROUNDS, else pick a new target and go to SHOW.
- Timer width is $clog2 of max(WINDOW_TICKS, GAP_TICKS) + 1. It decrements by one per cycle.

## Timing
- Reset assertion clears everything asynchronously: target=0, score_pulse=0, miss_pulse=0, busy=0, round_cnt=0, state IDLE, LFSR=LFSR_SEED, window=WINDOW_TICKS. Release is sampled synchronously.
- All outputs are registered.
- start sampled at edge N: target and busy valid from cycle N+1.
- Without a response, target stays lit for exactly the window length in cycles.
- A decisive btn_hit sampled at edge M produces the following in cycle M+1:
  - score_pulse or miss_pulse high for exactly one cycle
  - target=0
  - round_cnt incremented
- Gap is exactly GAP_TICKS dark cycles. The next target appears in the following cycle.
- At most one score/miss pulse per prompt. The two pulses are never high together.
- Reset mid-game aborts immediately. No pulse is emitted.

## Configuration
- TARGET_SPEEDUP_EN defined:
  - A window register loads WINDOW_TICKS on start.
  - Each score applies window := max(window - (window>>3), MIN_WINDOW_TICKS), effective from the next prompt.
  - Misses leave window unchanged.
- Undefined: the window is always WINDOW_TICKS. MIN_WINDOW_TICKS is ignored and no window register is synthesized.

## Structure
- Package target_seq_pkg holds:
  - state enum (IDLE, SHOW, GAP, DONE)
  - N_TARGETS=3
  - LFSR_TAPS=16'hB400
  - round_cnt width constant (6)
- Sub-module lfsr16 (clk, reset, seed parameter, 16-bit state out). Target mapping and FSM stay in target_sequencer.

## Test plan
- Bench parameters WINDOW_TICKS=8, GAP_TICKS=4, ROUNDS=3. Reset, then start pulse → target one-hot and busy=1 one cycle later. First idx matches the reference LFSR model.
- Matching btn_hit in the 3rd SHOW cycle → score_pulse for 1 cycle, target=0 for 4 cycles, round_cnt=1, then a new target.
- No press → target lit for 8 cycles, then miss_pulse for 1 cycle, round_cnt increments.
- Wrong bit pressed, then btn_hit=3'b011 on the next prompt → miss_pulse each time, score_pulse never asserts.
- Full game of 3 prompts → DONE, busy=0, round_cnt=3 held. Press during GAP → ignored. New start → round_cnt=0.
- Assert reset mid-SHOW → all outputs 0 immediately, LFSR=16'hACE1. With TARGET_SPEEDUP_EN, two scores give windows 8 → 7 → 7 (7>>3 = 0; with MIN_WINDOW_TICKS=6).

Source files
------------

// File: rtl/target_seq_pkg.sv
// Shared types and constants for the reaction-game target sequencer.
// Holds the FSM encoding, LFSR taps, counter width and the target-index mapping.
package target_seq_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SHOW = 2'd1,
        ST_GAP  = 2'd2,
        ST_DONE = 2'd3
    } state_e;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_SHOW = 2'd1;
    localparam logic [1:0] S_GAP  = 2'd2;
    localparam logic [1:0] S_DONE = 2'd3;

    localparam int          N_TARGETS = 3;
    localparam logic [15:0] LFSR_TAPS = 16'hB400;
    localparam int          RCNT_W    = 6;

    // Raw value 3 has no LED, so it rotates past the previous prompt instead.
    function automatic logic [1:0] map_idx(input logic [1:0] raw, input logic [1:0] prev);
        logic [1:0] idx;
        if (raw == 2'd3) begin
            idx = (prev == 2'd2) ? 2'd0 : prev + 2'd1;
        end else begin
            idx = raw;
        end
        return idx;
    endfunction

endpackage

// File: rtl/target_sequencer_lfsr16.sv
// Free-running 16-bit Galois LFSR (right-shifting, taps from target_seq_pkg).
module lfsr16
    import target_seq_pkg::*;
#(
    parameter logic [15:0] SEED = 16'hACE1
) (
    input  logic        clk,
    input  logic        reset,
    output logic [15:0] state
);

    // Advance one Galois step every clock; seed on reset.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= SEED;
        end else begin
            state <= (state >> 1) ^ (state[0] ? LFSR_TAPS : 16'h0000);
        end
    end

endmodule

// File: rtl/target_sequencer.sv
// Reaction-game prompt generator: lights pseudo-random targets, times the window, scores hits.
// Optional macro TARGET_SPEEDUP_EN shrinks the window by 1/8 after each score.
module target_sequencer
    import target_seq_pkg::*;
#(
    parameter int          WINDOW_TICKS     = 50_000_000,
    parameter int          GAP_TICKS        = 12_500_000,
    parameter int          ROUNDS           = 60,
    parameter int          MIN_WINDOW_TICKS = 12_500_000,
    parameter logic [15:0] LFSR_SEED        = 16'hACE1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [2:0]        btn_hit,
    output logic [2:0]        target,
    output logic              score_pulse,
    output logic              miss_pulse,
    output logic              busy,
    output logic [RCNT_W-1:0] round_cnt
);

    localparam int MAX_TICKS = (WINDOW_TICKS > GAP_TICKS) ? WINDOW_TICKS : GAP_TICKS;
    localparam int TW        = $clog2(MAX_TICKS) + 1;

    logic [15:0]   lfsr_s;
    logic          unused_lfsr_s;
    logic [1:0]    state_r;
    logic [TW-1:0] timer_r;
    logic [TW-1:0] window_s;
    logic [1:0]    prev_idx_r;
    logic [1:0]    pick_idx_s;
    logic [2:0]    pick_onehot_s;
    logic          decisive_s;
    logic          score_s;

    lfsr16 #(.SEED(LFSR_SEED)) u_lfsr (
        .clk   (clk),
        .reset (reset),
        .state (lfsr_s)
    );

    assign unused_lfsr_s = ^lfsr_s[15:2];

`ifdef TARGET_SPEEDUP_EN
    logic [TW-1:0] window_r;
    logic [TW-1:0] shrunk_s;
    logic [TW-1:0] window_next_s;

    // Next window after a score, clamped at the floor.
    always_comb begin
        shrunk_s = window_r - (window_r >> 3);
        if (shrunk_s < TW'(MIN_WINDOW_TICKS)) begin
            window_next_s = TW'(MIN_WINDOW_TICKS);
        end else begin
            window_next_s = shrunk_s;
        end
    end

    // Window reloads each game and tightens only on scores.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            window_r <= TW'(WINDOW_TICKS);
        end else if ((state_r == S_IDLE || state_r == S_DONE) && start) begin
            window_r <= TW'(WINDOW_TICKS);
        end else if (state_r == S_SHOW && decisive_s && score_s) begin
            window_r <= window_next_s;
        end
    end

    assign window_s = window_r;
`else
    localparam int unused_min_window = MIN_WINDOW_TICKS;
    assign window_s = TW'(WINDOW_TICKS);
`endif

    // Target choice and hit classification for the current cycle.
    always_comb begin
        pick_idx_s    = map_idx(lfsr_s[1:0], prev_idx_r);
        pick_onehot_s = 3'b001 << pick_idx_s;
        score_s       = (btn_hit == target);
        decisive_s    = (btn_hit != 3'b000) || (timer_r == {TW{1'b0}});
    end

    // Game FSM; all player-facing outputs are registered here.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r     <= S_IDLE;
            timer_r     <= {TW{1'b0}};
            prev_idx_r  <= 2'd0;
            target      <= 3'b000;
            score_pulse <= 1'b0;
            miss_pulse  <= 1'b0;
            busy        <= 1'b0;
            round_cnt   <= {RCNT_W{1'b0}};
        end else begin
            score_pulse <= 1'b0;
            miss_pulse  <= 1'b0;
            case (state_r)
                S_IDLE, S_DONE: begin
                    if (start) begin
                        round_cnt  <= {RCNT_W{1'b0}};
                        prev_idx_r <= pick_idx_s;
                        target     <= pick_onehot_s;
                        busy       <= 1'b1;
                        timer_r    <= TW'(WINDOW_TICKS - 1);
                        state_r    <= S_SHOW;
                    end
                end
                S_SHOW: begin
                    if (decisive_s) begin
                        score_pulse <= score_s;
                        miss_pulse  <= !score_s;
                        target      <= 3'b000;
                        round_cnt   <= round_cnt + {{(RCNT_W-1){1'b0}}, 1'b1};
                        timer_r     <= TW'(GAP_TICKS - 1);
                        state_r     <= S_GAP;
                    end else begin
                        timer_r <= timer_r - {{(TW-1){1'b0}}, 1'b1};
                    end
                end
                S_GAP: begin
                    if (timer_r == {TW{1'b0}}) begin
                        if (round_cnt == RCNT_W'(ROUNDS)) begin
                            busy    <= 1'b0;
                            state_r <= S_DONE;
                        end else begin
                            prev_idx_r <= pick_idx_s;
                            target     <= pick_onehot_s;
                            timer_r    <= window_s - {{(TW-1){1'b0}}, 1'b1};
                            state_r    <= S_SHOW;
                        end
                    end else begin
                        timer_r <= timer_r - {{(TW-1){1'b0}}, 1'b1};
                    end
                end
                default: begin
                    target  <= 3'b000;
                    busy    <= 1'b0;
                    state_r <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_target_sequencer.sv
// Self-checking bench for target_sequencer: prompt-level reference model plus directed literal checks.
// Honours TARGET_SPEEDUP_EN the same way as the design.
module tb_target_sequencer;

    localparam int W    = 8;
    localparam int G    = 4;
    localparam int R    = 3;
    localparam int WMIN = 6;

    logic       clk;
    logic       reset;
    logic       start;
    logic [2:0] btn_hit;
    logic [2:0] target;
    logic       score_pulse;
    logic       miss_pulse;
    logic       busy;
    logic [5:0] round_cnt;

    int  vectors;
    int  miscompares;
    bit  chk_en;

    target_sequencer #(
        .WINDOW_TICKS     (W),
        .GAP_TICKS        (G),
        .ROUNDS           (R),
        .MIN_WINDOW_TICKS (WMIN),
        .LFSR_SEED        (16'hACE1)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .btn_hit     (btn_hit),
        .target      (target),
        .score_pulse (score_pulse),
        .miss_pulse  (miss_pulse),
        .busy        (busy),
        .round_cnt   (round_cnt)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // ---------------- reference model (prompt level) ----------------
    logic [15:0] m_lfsr;
    int          m_mode;      // 0 idle, 1 lit, 2 dark, 3 finished
    int          m_prev;
    int          m_lit;
    int          m_dark;
    int          m_window;
    int          m_cur_window;
    logic [2:0]  exp_target;
    logic        exp_score;
    logic        exp_miss;
    logic        exp_busy;
    logic [5:0]  exp_round;

    function automatic logic [15:0] lfsr_next(input logic [15:0] s);
        return s[0] ? ((s >> 1) ^ 16'hB400) : (s >> 1);
    endfunction

    task automatic m_launch();
        int raw;
        int idx;
        raw = int'(m_lfsr[1:0]);
        idx = (raw == 3) ? (m_prev + 1) % 3 : raw;
        m_prev       = idx;
        exp_target   = 3'(1 << idx);
        exp_busy     = 1'b1;
        m_lit        = 0;
        m_cur_window = m_window;
        m_mode       = 1;
    endtask

    task automatic m_finish(input bit scored);
        exp_target = 3'b000;
        exp_round  = exp_round + 6'd1;
        m_dark     = 0;
        m_mode     = 2;
`ifdef TARGET_SPEEDUP_EN
        if (scored) begin
            m_window = m_window - m_window / 8;
            if (m_window < WMIN) m_window = WMIN;
        end
`else
        if (scored) m_window = W;
`endif
    endtask

    initial begin
        forever begin
            @(posedge clk or negedge reset);
            if (!reset) begin
                m_lfsr = 16'hACE1; m_mode = 0; m_prev = 0; m_lit = 0; m_dark = 0;
                m_window = W; m_cur_window = W;
                exp_target = 3'b000; exp_score = 1'b0; exp_miss = 1'b0;
                exp_busy = 1'b0; exp_round = 6'd0;
            end else begin
                exp_score = 1'b0;
                exp_miss  = 1'b0;
                case (m_mode)
                    0, 3: begin
                        if (start) begin
                            exp_round = 6'd0;
                            m_window  = W;
                            m_launch();
                        end
                    end
                    1: begin
                        m_lit++;
                        if (btn_hit != 3'b000) begin
                            if (btn_hit == exp_target) exp_score = 1'b1;
                            else exp_miss = 1'b1;
                            m_finish(exp_score);
                        end else if (m_lit == m_cur_window) begin
                            exp_miss = 1'b1;
                            m_finish(1'b0);
                        end
                    end
                    2: begin
                        m_dark++;
                        if (m_dark == G) begin
                            if (int'(exp_round) == R) begin
                                exp_busy = 1'b0;
                                m_mode   = 3;
                            end else begin
                                m_launch();
                            end
                        end
                    end
                    default: m_mode = 0;
                endcase
                m_lfsr = lfsr_next(m_lfsr);
            end
        end
    end

    // Compare every cycle against the model, away from the active edge.
    initial begin
        forever begin
            @(negedge clk);
            if (chk_en) begin
                vectors++;
                if (target !== exp_target || score_pulse !== exp_score || miss_pulse !== exp_miss ||
                    busy !== exp_busy || round_cnt !== exp_round) begin
                    miscompares++;
                    $display("FAIL model_cycle t=%0t got tgt=%b sc=%b ms=%b busy=%b rnd=%0d want tgt=%b sc=%b ms=%b busy=%b rnd=%0d",
                             $time, target, score_pulse, miss_pulse, busy, round_cnt,
                             exp_target, exp_score, exp_miss, exp_busy, exp_round);
                end
            end
        end
    end

    // ---------------- directed helpers ----------------
    task automatic check(input string name, input logic [15:0] got, input logic [15:0] want);
        vectors++;
        if (got !== want) begin
            miscompares++;
            $display("FAIL %s got=%h want=%h t=%0t", name, got, want, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic count_lit(output int n);
        n = 0;
        while (target != 3'b000 && n < 50) begin
            n++;
            tick();
        end
    endtask

    task automatic count_dark(output int n);
        n = 0;
        while (target == 3'b000 && busy && n < 50) begin
            n++;
            tick();
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    // ---------------- directed stimulus ----------------
    initial begin
        int n;
        logic [2:0] wrong;
        vectors = 0; miscompares = 0; chk_en = 1'b0;
        reset = 1'b1; start = 1'b0; btn_hit = 3'b000;
        #2 reset = 1'b0;
        @(negedge clk);
        chk_en = 1'b1;
        check("rst_target", 16'(target), 16'h0000);
        check("rst_busy", 16'(busy), 16'h0000);
        check("rst_round", 16'(round_cnt), 16'h0000);
        check("rst_lfsr", dut.u_lfsr.state, 16'hACE1);
        reset = 1'b1;
        tick(); tick();
        check("lfsr_2steps_dut", dut.u_lfsr.state, 16'h7138);
        check("lfsr_2steps_model", m_lfsr, 16'h7138);

        // Game 1: 0x7138 -> idx 0
        start = 1'b1;
        tick();
        start = 1'b0;
        check("first_target", 16'(target), 16'h0001);
        check("first_busy", 16'(busy), 16'h0001);
        tick(); tick();
        btn_hit = 3'b001;          // 3rd lit cycle
        tick();
        btn_hit = 3'b000;
        check("hit_score", 16'(score_pulse), 16'h0001);
        check("hit_dark", 16'(target), 16'h0000);
        check("hit_round", 16'(round_cnt), 16'h0001);
        count_dark(n);
        check("gap_len_1", 16'(n), 16'd4);

        count_lit(n);              // no press
        check("window_len", 16'(n), 16'd8);
        check("timeout_miss", 16'(miss_pulse), 16'h0001);
        check("timeout_round", 16'(round_cnt), 16'h0002);
        count_dark(n);
        check("gap_len_2", 16'(n), 16'd4);

        wrong = {exp_target[1:0], exp_target[2]};
        btn_hit = wrong;
        tick();
        btn_hit = 3'b000;
        check("wrong_miss", 16'(miss_pulse), 16'h0001);
        check("wrong_no_score", 16'(score_pulse), 16'h0000);
        btn_hit = 3'b111;          // ignored during gap
        tick();
        btn_hit = 3'b000;
        count_dark(n);
        tick(); tick();
        check("done_busy", 16'(busy), 16'h0000);
        check("done_round", 16'(round_cnt), 16'h0003);
        check("done_target", 16'(target), 16'h0000);

        // Game 2: multi-bit press, then reset mid-prompt
        start = 1'b1;
        tick();
        start = 1'b0;
        check("restart_round", 16'(round_cnt), 16'h0000);
        check("restart_busy", 16'(busy), 16'h0001);
        btn_hit = 3'b011;
        tick();
        btn_hit = 3'b000;
        check("multi_miss", 16'(miss_pulse), 16'h0001);
        check("multi_no_score", 16'(score_pulse), 16'h0000);
        count_dark(n);
        tick();
        #2 reset = 1'b0;
        #1;
        check("abort_target", 16'(target), 16'h0000);
        check("abort_busy", 16'(busy), 16'h0000);
        check("abort_pulses", 16'({score_pulse, miss_pulse}), 16'h0000);
        check("abort_round", 16'(round_cnt), 16'h0000);
        check("abort_lfsr", dut.u_lfsr.state, 16'hACE1);
        @(negedge clk);
        reset = 1'b1;

        // Game 3: two scores then a timeout shows the effective window
        tick();
        start = 1'b1;
        tick();
        start = 1'b0;
        btn_hit = exp_target;
        tick();
        btn_hit = 3'b000;
        check("speed_score1", 16'(score_pulse), 16'h0001);
        count_dark(n);
        btn_hit = exp_target;
        tick();
        btn_hit = 3'b000;
        check("speed_score2", 16'(score_pulse), 16'h0001);
        count_dark(n);
        count_lit(n);
`ifdef TARGET_SPEEDUP_EN
        check("speed_window", 16'(n), 16'd7);
`else
        check("speed_window", 16'(n), 16'd8);
`endif
        count_dark(n);
        tick();
        check("game3_done", 16'(busy), 16'h0000);

        chk_en = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
